// File: rtl/mem_port_master_pkg.sv
// Shared definitions for the data-RAM initiator port.
// Contents:
//   DATA_W / ADDR_W   default word and byte-address widths
//   SZ_*              request size codes carried on req_size
//   state_t           FSM state encoding (3 bits), also exposed on dbg_state
//   is_bad_req()      misalignment / reserved-size check done at accept time
package mem_port_master_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ERR        = 3'd1,
        ST_WRITE      = 3'd2,
        ST_RD_ISSUE   = 3'd3,
        ST_RD_WAIT    = 3'd4,
        ST_RD_CAPTURE = 3'd5,
        ST_MERGE_WR   = 3'd6,
        ST_RESP       = 3'd7
    } state_t;

    // Halves must sit on an even byte, words on a 4-byte boundary.
    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_master_lane_align.sv
// Combinational lane steering between a 32-bit RAM word and sub-word data.
// Ports:
//   size        request size code (SZ_BYTE/SZ_HALF/SZ_WORD)
//   is_unsigned 1 = zero-extend loads, 0 = sign-extend
//   addr_lo     byte offset inside the word (little-endian lanes)
//   word        word read from the RAM
//   wdata       right-aligned store data (byte in [7:0], half in [15:0])
//   load_data   extracted and extended load result
//   merge_data  word with the addressed lane(s) replaced by wdata
module mem_port_master_lane_align
    import mem_port_master_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_lsb = {addr_lo, 3'b000};
    assign half_lsb = {addr_lo[1], 4'b0000};

    always_comb begin
        byte_sel   = word[byte_lsb +: 8];
        half_sel   = word[half_lsb +: 16];
        load_data  = word;
        merge_data = word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merge_data[byte_lsb +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merge_data[half_lsb +: 16] = wdata;
            end
            default: begin
                load_data  = word;
                merge_data = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_master.sv
// Initiator side of the core data-RAM port.
// Takes one load/store at a time from the LSU, drives the RAM (2-cycle read
// latency), runs sub-word stores as read-modify-write and returns extended
// load data.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (req_ready high only in IDLE)
//   req_we/req_size/req_unsigned  store flag, size code, load zero-extend
//   req_addr/req_wdata            byte address, right-aligned store data
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err             load data (0 for stores/errors), error flag
//   mem_write_en/mem_read_en      RAM strobes (never both high)
//   mem_address/mem_data_in       RAM word address (low bits 00), write data
//   mem_data_out                  RAM read data, used only in RD_CAPTURE
//   dbg_state                     current FSM state
//
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high. The sender holds valid and its payload stable until that edge; the
// receiver may drive ready independently of valid.
module mem_port_master
    import mem_port_master_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output state_t                dbg_state
);

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_q;

    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign dbg_state = state;

    // Steering works on the live RAM output; it is only consumed in RD_CAPTURE,
    // which keeps stale read-pipeline data (e.g. after a reset) out of the result.
    mem_port_master_lane_align u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .addr_lo     (addr_lo_q),
        .word        (mem_data_out),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_lo_q    <= 2'b00;
            wdata_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_lo_q  <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        req_ready  <= 1'b0;
                        if (is_bad_req(req_size, req_addr[1:0])) begin
                            state <= ST_ERR;
                        end else if (req_we && req_size == SZ_WORD) begin
                            mem_address  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_write_en <= 1'b1;
                            mem_data_in  <= req_wdata;
                            state        <= ST_WRITE;
                        end else begin
                            // Address is set here and held through the whole read:
                            // the RAM samples it on both clock edges.
                            mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_read_en <= 1'b1;
                            state       <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_ERR: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                    state     <= ST_RESP;
                end
                ST_WRITE: begin
                    mem_write_en <= 1'b0;
                    mem_data_in  <= '0;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RD_ISSUE: begin
                    mem_read_en <= 1'b0;
                    state       <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state <= ST_RD_CAPTURE;
                end
                ST_RD_CAPTURE: begin
                    if (we_q) begin
                        mem_write_en <= 1'b1;
                        mem_data_in  <= merge_data;
                        state        <= ST_MERGE_WR;
                    end else begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_MERGE_WR: begin
                    mem_write_en <= 1'b0;
                    mem_data_in  <= '0;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        mem_address <= '0;
                        req_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_master.sv
module tb_mem_port_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic [2:0]  dbg_state;

    int compared = 0;
    int mismatched = 0;

    // {err, rdata}
    logic [32:0] exp_q[$];

    int  rd_cnt = 0;
    int  wr_cnt = 0;
    logic both_high = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- DUT ----------------
    mem_port_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .dbg_state    (dbg_state)
    );

    // ---------------- RAM model: 80 words, 2-cycle read, output stage ----------------
    logic [31:0] ram [0:79];
    logic        rd_en1 = 1'b0;
    logic [31:0] rd_d1 = '0;

    initial begin
        mem_data_out = '0;
        for (int i = 0; i < 80; i++) ram[i] = '0;
        ram[8] = 32'h8899AABB;
    end

    always @(posedge clk) begin
        if (mem_write_en) ram[mem_address[8:2]] <= mem_data_in;
        rd_en1       <= mem_read_en;
        rd_d1        <= ram[mem_address[8:2]];
        mem_data_out <= rd_en1 ? rd_d1 : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_read_en)  rd_cnt++;
        if (mem_write_en) wr_cnt++;
        if (mem_read_en && mem_write_en) both_high = 1'b1;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rsp_unexpected: got rdata 0x%08h err %0b expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
                check("rsp_rdata", rsp_rdata, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e,
                          input int exp_lat, input int exp_rd, input int exp_wr,
                          input int hold);
        int lat;
        wait_ready();
        rd_cnt       = 0;
        wr_cnt       = 0;
        rsp_ready    = (hold == 0);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        exp_q.push_back({exp_e, exp_d});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        check("latency", 32'(lat), 32'(exp_lat));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                check("bp_rsp_rdata", rsp_rdata, exp_d);
                check("bp_req_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rd_pulses", 32'(rd_cnt), 32'(exp_rd));
        check("wr_pulses", 32'(wr_cnt), 32'(exp_wr));
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_mem_en", {30'b0, mem_write_en, mem_read_en}, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);

        // word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 0);
        check("ram_sw", ram[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4, 1, 0, 0);

        // sub-word loads from preloaded 0x8899AABB @0x20
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0, 4, 1, 0, 0);
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h000000AA, 1'b0, 4, 1, 0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF8899, 1'b0, 4, 1, 0, 0);
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h00008899, 1'b0, 4, 1, 0, 0);

        // sub-word stores (read-modify-write); upper store bits must be ignored
        do_req(1'b1, 2'b00, 1'b0, 32'h23, 32'hFFFFFF11, 32'h0, 1'b0, 5, 1, 1, 0);
        check("ram_sb", ram[8], 32'h1199AABB);
        do_req(1'b1, 2'b01, 1'b0, 32'h20, 32'hABCD5566, 32'h0, 1'b0, 5, 1, 1, 0);
        check("ram_sh", ram[8], 32'h11995566);

        // errors: no RAM access, RAM unchanged
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 2, 0, 0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 2, 0, 0, 0);
        do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 2, 0, 0, 0);
        check("ram_err_w4", ram[4], 32'hDEADBEEF);
        check("ram_err_w8", ram[8], 32'h11995566);

        // backpressure on a word load
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4, 1, 0, 5);

        // reset during RD_WAIT of a sub-word store
        wait_ready();
        wr_cnt       = 0;
        rsp_ready    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h20;
        req_wdata    = 32'h77;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_test_in_wait", 32'(dbg_state), 32'd4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        check("midrst_mem_en", {30'b0, mem_write_en, mem_read_en}, 32'd0);
        check("midrst_mem_addr", mem_address, 32'd0);
        // load immediately while the RAM output stage still carries the stale read
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11995566, 1'b0, 4, 1, 0, 0);
        check("midrst_no_write", 32'(wr_cnt), 32'd0);
        check("ram_after_rst", ram[8], 32'h11995566);

        repeat (3) @(negedge clk);
        check("strobes_exclusive", 32'(both_high), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
